elixirchip_es1_spu_op_acc: RTL and testbench

//   Pipelined accumulator SPU op: m_data accumulates s_data on each valid beat, with clear and carry/saturation flag.

---
 rtl/elixirchip_es1_spu_pkg.sv | 17 +
 rtl/elixirchip_es1_spu_op_delay.sv | 51 +++++
 rtl/elixirchip_es1_spu_op_acc.sv | 131 +++++++++++++
 tb/tb_elixirchip_es1_spu_op_acc.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/elixirchip_es1_spu_pkg.sv
// Shared types and constants for the ElixirChip ES1 SPU accumulator op.
package elixirchip_es1_spu_pkg;

    // The adder produces one bit more than the data width: the carry-out.
    localparam int CARRY_BITS = 1;

    // Per-stage control bits that travel alongside the accumulator data.
    typedef struct packed {
        logic carry;
        logic valid;
    } acc_flag_t;

    function automatic int sum_bits(input int data_bits);
        return data_bits + CARRY_BITS;
    endfunction

endpackage

// File: rtl/elixirchip_es1_spu_op_delay.sv
// Clock-enabled, resettable delay line of DEPTH stages.
// Each stage's payload only loads when the beat entering it is valid,
// so the output payload holds its last valid value between beats.
// DEPTH=0 degenerates to a straight wire.
module elixirchip_es1_spu_op_delay #(
    parameter int               DEPTH      = 1,
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cke,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid
);

    if (DEPTH == 0) begin : g_wire
        assign m_data  = s_data;
        assign m_valid = s_valid;
    end else begin : g_pipe
        logic [WIDTH-1:0] data_q [DEPTH];
        logic [DEPTH-1:0] valid_q;

        // Shift valid every enabled cycle; advance payload only behind a valid beat.
        always_ff @(posedge clk) begin
            if (reset) begin
                valid_q <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    data_q[i] <= RESET_DATA;
                end
            end else if (cke) begin
                valid_q[0] <= s_valid;
                if (s_valid) begin
                    data_q[0] <= s_data;
                end
                for (int i = 1; i < DEPTH; i++) begin
                    valid_q[i] <= valid_q[i-1];
                    if (valid_q[i-1]) begin
                        data_q[i] <= data_q[i-1];
                    end
                end
            end
        end

        assign m_data  = data_q[DEPTH-1];
        assign m_valid = valid_q[DEPTH-1];
    end

endmodule

// File: rtl/elixirchip_es1_spu_op_acc.sv
// Pipelined accumulator SPU op.
// Stage 0 adds s_data into the running accumulator (optionally cleared first);
// a delay line adds LATENCY-1 further stages. Output data/carry only change
// on valid beats.
// Build option: define ELIXIRCHIP_ES1_SPU_OP_ACC_SAT_EN for unsigned saturation
// (sticky until clear/reset) instead of modulo wrap.
module elixirchip_es1_spu_op_acc
    import elixirchip_es1_spu_pkg::*;
#(
    parameter int   LATENCY    = 1,
    parameter int   DATA_BITS  = 8,
    parameter type  data_t     = logic [DATA_BITS-1:0],
    parameter data_t CLEAR_DATA = '0,
    parameter       DEVICE     = "RTL",
    parameter       SIMULATION = "false",
    parameter       DEBUG      = "false"
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  cke,
    input  data_t s_data,
    input  logic  s_clear,
    input  logic  s_valid,
    output data_t m_data,
    output logic  m_carry,
    output logic  m_valid
);

    localparam int W        = $bits(data_t);
    localparam int SUM_BITS = sum_bits(W);

    data_t               acc;
    data_t               base;
    logic [SUM_BITS-1:0] sum;
    data_t               add_data;
    logic                add_carry;
    data_t               st0_data;
    acc_flag_t           st0_flag;

`ifdef ELIXIRCHIP_ES1_SPU_OP_ACC_SAT_EN
    logic sat;

    // Clear-then-add, clamping to all ones once the sum overflows and staying there.
    always_comb begin
        base = s_clear ? CLEAR_DATA : acc;
        sum  = {1'b0, base} + {1'b0, s_data};
        if (sum[W] || (sat && !s_clear)) begin
            add_data  = '1;
            add_carry = 1'b1;
        end else begin
            add_data  = sum[W-1:0];
            add_carry = 1'b0;
        end
    end

    // Sticky saturation flag, released only by clear or reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sat <= 1'b0;
        end else if (cke) begin
            if (s_valid) begin
                sat <= add_carry;
            end else if (s_clear) begin
                sat <= 1'b0;
            end
        end
    end
`else
    // Clear-then-add with modulo wrap; the extra sum bit is the carry-out.
    always_comb begin
        base      = s_clear ? CLEAR_DATA : acc;
        sum       = {1'b0, base} + {1'b0, s_data};
        add_data  = sum[W-1:0];
        add_carry = sum[W];
    end
`endif

    // Stage 0: accumulator plus the held result/carry of the last valid beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc            <= CLEAR_DATA;
            st0_data       <= CLEAR_DATA;
            st0_flag.carry <= 1'b0;
            st0_flag.valid <= 1'b0;
        end else if (cke) begin
            st0_flag.valid <= s_valid;
            if (s_valid) begin
                acc            <= add_data;
                st0_data       <= add_data;
                st0_flag.carry <= add_carry;
            end else if (s_clear) begin
                acc <= CLEAR_DATA;
            end
        end
    end

    if (LATENCY > 1) begin : g_delay
        logic [W:0] dly_data;

        elixirchip_es1_spu_op_delay #(
            .DEPTH      (LATENCY - 1),
            .WIDTH      (W + 1),
            .RESET_DATA ({CLEAR_DATA, 1'b0})
        ) u_delay (
            .clk     (clk),
            .reset   (reset),
            .cke     (cke),
            .s_data  ({st0_data, st0_flag.carry}),
            .s_valid (st0_flag.valid),
            .m_data  (dly_data),
            .m_valid (m_valid)
        );

        assign m_data  = dly_data[W:1];
        assign m_carry = dly_data[0];
    end else begin : g_direct
        assign m_data  = st0_data;
        assign m_carry = st0_flag.carry;
        assign m_valid = st0_flag.valid;
    end

    if (SIMULATION == "true" || DEBUG == "true" || DEVICE == "") begin : g_sim_check
        // An unknown valid after reset would silently corrupt the accumulator.
        always_ff @(posedge clk) begin
            if (!reset) begin
                assert (!$isunknown(s_valid));
            end
        end
    end

endmodule

// File: tb/tb_elixirchip_es1_spu_op_acc.sv
// Bench for elixirchip_es1_spu_op_acc: two instances (LATENCY 1 and 5, 8-bit)
// share stimulus; a queue-based reference model checks both every cycle.
module tb_elixirchip_es1_spu_op_acc;

    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cke;
    logic [DB-1:0] s_data;
    logic          s_clear;
    logic          s_valid;
    logic [DB-1:0] m_data1, m_data5;
    logic          m_carry1, m_carry5;
    logic          m_valid1, m_valid5;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    elixirchip_es1_spu_op_acc #(.LATENCY(1), .DATA_BITS(DB)) dut1 (
        .clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_clear(s_clear),
        .s_valid(s_valid), .m_data(m_data1), .m_carry(m_carry1), .m_valid(m_valid1)
    );

    elixirchip_es1_spu_op_acc #(.LATENCY(5), .DATA_BITS(DB)) dut5 (
        .clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_clear(s_clear),
        .s_valid(s_valid), .m_data(m_data5), .m_carry(m_carry5), .m_valid(m_valid5)
    );

    always @(posedge clk) begin
        if (reset === 1'b0) begin
            assert (!$isunknown(s_valid));
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic          v;
        logic [DB-1:0] d;
        logic          c;
    } beat_t;

    beat_t         hist[$];     // index 0 = beat produced on the latest enabled edge
    int unsigned   mdl_acc;
    bit            mdl_sat;
    int            lat[2] = '{1, 5};
    logic [DB-1:0] held_d[2];
    logic          held_c[2];

    function automatic void model_reset();
        beat_t idle;
        idle.v = 1'b0; idle.d = '0; idle.c = 1'b0;
        mdl_acc = 0;
        mdl_sat = 1'b0;
        hist.delete();
        for (int i = 0; i < 8; i++) hist.push_back(idle);
        for (int j = 0; j < 2; j++) begin
            held_d[j] = '0;
            held_c[j] = 1'b0;
        end
    endfunction

    function automatic void model_edge();
        beat_t       b;
        int unsigned base;
        int unsigned sum;
        if (reset) begin
            model_reset();
            return;
        end
        if (!cke) return;
        b.v = 1'b0; b.d = '0; b.c = 1'b0;
        if (s_valid) begin
            base = s_clear ? 0 : mdl_acc;
            sum  = base + 32'(s_data);
`ifdef ELIXIRCHIP_ES1_SPU_OP_ACC_SAT_EN
            if (sum > 255 || (mdl_sat && !s_clear)) begin
                b.d = 8'hFF; b.c = 1'b1; mdl_sat = 1'b1;
            end else begin
                b.d = sum[7:0]; b.c = 1'b0; mdl_sat = 1'b0;
            end
`else
            b.d = 8'(sum % 256);
            b.c = (sum > 255);
`endif
            b.v = 1'b1;
            mdl_acc = 32'(b.d);
        end else if (s_clear) begin
            mdl_acc = 0;
            mdl_sat = 1'b0;
        end
        hist.push_front(b);
        void'(hist.pop_back());
        for (int j = 0; j < 2; j++) begin
            if (hist[lat[j]-1].v) begin
                held_d[j] = hist[lat[j]-1].d;
                held_c[j] = hist[lat[j]-1].c;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("l1_valid", 32'(m_valid1), 32'(hist[0].v));
        chk("l1_data",  32'(m_data1),  32'(held_d[0]));
        chk("l1_carry", 32'(m_carry1), 32'(held_c[0]));
        chk("l5_valid", 32'(m_valid5), 32'(hist[4].v));
        chk("l5_data",  32'(m_data5),  32'(held_d[1]));
        chk("l5_carry", 32'(m_carry5), 32'(held_c[1]));
    endtask

    task automatic step(input logic r, input logic k, input logic c, input logic v,
                        input logic [DB-1:0] d);
        reset = r; cke = k; s_clear = c; s_valid = v; s_data = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    // ---------------- directed table (expectations for the LATENCY=1 instance) ----------------
    typedef struct {
        logic          r, k, c, v;
        logic [DB-1:0] d;
        logic          ev;
        logic [DB-1:0] ed;
        logic          ec;
    } vec_t;

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 1'b1, 8'h10, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h20, 1'b1, 8'h30, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h05, 1'b1, 8'h35, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hAA, 1'b0, 8'h35, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hF0, 1'b1, 8'hF0, 1'b0};
`ifdef ELIXIRCHIP_ES1_SPU_OP_ACC_SAT_EN
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h20, 1'b1, 8'hFF, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 8'hFF, 1'b1};
`else
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h20, 1'b1, 8'h10, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 8'h11, 1'b0};
`endif
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 8'h03, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h3D, 1'b1, 8'h40, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h40, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h07, 1'b1, 8'h07, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 8'h07, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h07, 1'b0};
    end

    // ---------------- test sequence ----------------
    initial begin
        bit seen;
        reset = 1'b1; cke = 1'b1; s_clear = 1'b0; s_valid = 1'b0; s_data = '0;
        model_reset();
        @(negedge clk);

        // Directed table: T1 basic, T2/T3 wrap or saturate, T4 clear, cke freeze.
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].r, tbl[i].k, tbl[i].c, tbl[i].v, tbl[i].d);
            chk($sformatf("tbl%0d_valid", i), 32'(m_valid1), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_data", i),  32'(m_data1),  32'(tbl[i].ed));
            chk($sformatf("tbl%0d_carry", i), 32'(m_carry1), 32'(tbl[i].ec));
        end

        // T6: three beats in flight in the LATENCY=5 pipe, one-cycle reset.
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h11);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h22);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h33);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            chk("t6_flushed_valid", 32'(m_valid5), 32'd0);
            chk("t6_flushed_data",  32'(m_data5),  32'd0);
        end
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h01);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (m_valid5 === 1'b1) seen = 1'b1;
            else step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        end
        chk("t6_beat_arrived", 32'(seen), 32'd1);
        chk("t6_beat_data",    32'(m_data5), 32'h01);
        chk("t6_beat_carry",   32'(m_carry5), 32'd0);

        // T5 and general random traffic: cke low ~50%, bursts, clears, rare resets.
        for (int n = 0; n < 3000; n++) begin
            logic r, k, c, v;
            r = ($urandom_range(0, 99) < 1);
            k = ($urandom_range(0, 1) == 1);
            c = ($urandom_range(0, 9) == 0);
            v = ($urandom_range(0, 2) != 0);
            step(r, k, c, v, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
